// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding, requester indices
// and the wait-counter load helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_idx_t;

  // Wide enough to hold RD_LAT-1 for the largest legal latency of 7.
  localparam int CNT_W = 3;

  function automatic logic [CNT_W-1:0] wait_load(input int rd_lat);
    return (rd_lat > 0) ? CNT_W'(rd_lat - 1) : '0;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU and DMA request/ack groups plus the memory macro port.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_wren;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_addr, mem_din, mem_wren,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_addr, mem_din, mem_wren,
    output mem_dout
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  output req_idx_t   gnt_idx,
  output logic       any
);

  always_comb begin
    any     = |req;
    gnt_idx = REQ_CPU;
    case (req)
      2'b01:   gnt_idx = REQ_CPU;
      2'b10:   gnt_idx = REQ_DMA;
      2'b11:   gnt_idx = (last == REQ_CPU) ? REQ_DMA : REQ_CPU;
      default: gnt_idx = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one code/data memory between the CPU and a
// DMA/loader engine; request/ack handshake per port, memory read latency RD_LAT (0..7).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  req_idx_t         last_reg, last_next;
  req_idx_t         sel_reg, sel_next;
  logic             wr_reg, wr_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [DW-1:0]    wdata_reg, wdata_next;
  logic [DW-1:0]    rdata_reg, rdata_next;

  req_idx_t gnt_idx;
  logic     any_req;

  rr_arb2 u_rr_arb2 (
    .req     ({bus.dma_req, bus.cpu_req}),
    .last    (last_reg),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= REQ_DMA;
      sel_reg   <= REQ_CPU;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      sel_reg   <= sel_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    sel_next   = sel_reg;
    wr_next    = wr_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;

    bus.mem_addr  = '0;
    bus.mem_din   = '0;
    bus.mem_wren  = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.dma_ack   = 1'b0;
    bus.dma_rdata = '0;
    busy          = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (any_req) begin
          sel_next   = gnt_idx;
          last_next  = gnt_idx;
          wr_next    = (gnt_idx == REQ_DMA) ? bus.dma_wr    : bus.cpu_wr;
          addr_next  = (gnt_idx == REQ_DMA) ? bus.dma_addr  : bus.cpu_addr;
          wdata_next = (gnt_idx == REQ_DMA) ? bus.dma_wdata : bus.cpu_wdata;
          // Write acks return zero data rather than a stale earlier read.
          rdata_next = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_addr = addr_reg;
        bus.mem_din  = wdata_reg;
        bus.mem_wren = wr_reg;
        if (wr_reg) begin
          state_next = ACK;
        end else if (RD_LAT == 0) begin
          rdata_next = bus.mem_dout;
          state_next = ACK;
        end else begin
          cnt_next   = wait_load(RD_LAT);
          state_next = WAIT;
        end
      end
      WAIT: begin
        bus.mem_addr = addr_reg;
        bus.mem_din  = wdata_reg;
        if (cnt_reg == '0) begin
          rdata_next = bus.mem_dout;
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ACK: begin
        if (sel_reg == REQ_CPU) begin
          bus.cpu_ack   = 1'b1;
          bus.cpu_rdata = rdata_reg;
        end else begin
          bus.dma_ack   = 1'b1;
          bus.dma_rdata = rdata_reg;
        end
        // One forced IDLE cycle keeps a just-acked request from being re-granted.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single mixed code/data memory between two requesters:
  - the multicycle MIPS core (CPU port);
  - a program loader/DMA engine (DMA port).
- Each access uses a request/acknowledge handshake.
- Requesters are selected round-robin.
- Supports a memory with configurable read latency.
- Sits between the core's memory interface and the memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- RD_LAT, 1, memory read latency in cycles from address presented to mem_dout valid. Legal range 0..7; 0 means combinational read.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU request; held until cpu_ack.
- cpu_wr  input  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  input  AW  CPU byte address.
- cpu_wdata  input  DW  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_rdata  output  DW  read data; valid while cpu_ack=1.
- dma_req, dma_wr, dma_addr, dma_wdata, dma_ack, dma_rdata: same as the CPU group, for the DMA port.
- mem_addr  output  AW  memory address.
- mem_din  output  DW  memory write data.
- mem_wren  output  1  memory write enable.
- mem_dout  input  DW  memory read data.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is asynchronous: rst=1 immediately forces state=IDLE, cnt=0, last=DMA.
- Reset values: every output is 0 (acks, rdata, mem_addr, mem_din, mem_wren, busy).
- Reset mid-transaction abandons the access: no ack is issued and mem_wren drops immediately.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - If any req=1, select a winner and latch its wr/addr/wdata into sel_q/wr_q/addr_q/wdata_q, then go to ISSUE.
  - Otherwise stay in IDLE.
- Selection rules:
  - Only one requester asserting → that one wins.
  - Both asserting → the one not equal to `last` wins.
  - `last` updates on the IDLE→ISSUE transition.
  - After reset the CPU wins the first tie.
- ISSUE:
  - mem_addr=addr_q, mem_din=wdata_q.
  - Write: mem_wren=1 for this single cycle; go to ACK.
  - Read, RD_LAT=0: capture mem_dout into rdata_q; go to ACK.
  - Read, RD_LAT>0: load cnt=RD_LAT-1 and go to WAIT, except when RD_LAT=1, which captures mem_dout at the end of the following WAIT cycle.
- WAIT:
  - mem_addr is held at addr_q; mem_wren=0.
  - If cnt==0: capture mem_dout into rdata_q and go to ACK.
  - Otherwise decrement cnt.
  - Read data is therefore sampled exactly RD_LAT cycles after the ISSUE cycle.
- ACK:
  - Pulse the ack of requester sel_q for exactly one cycle.
  - That port's rdata=rdata_q; the other port's ack is 0.
  - Go to IDLE unconditionally.
- Latency, with req sampled in IDLE at edge t:
  - ISSUE occupies cycle t+1.
  - Write ack occurs in cycle t+2.
  - Read ack occurs in cycle t+2+RD_LAT.
- Handshake rules:
  - req, wr, addr and wdata must stay stable until the ack cycle.
  - In the cycle after ack, the requester either deasserts req or presents a new transaction.
  - The single IDLE cycle after ACK guarantees a completed request is never re-granted.
- Between transactions, mem_addr, mem_din and mem_wren are 0 except during ISSUE/WAIT.
- A requester dropping req before ack is a protocol violation; the latched transaction completes regardless.
- Fairness: with both requesters continuously requesting, grants strictly alternate, so neither port waits more than one transaction.

Decomposition:
- Header mem_arb_def.v holds:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ACK=2'd3);
  - requester indices (REQ_CPU=1'b0, REQ_DMA=1'b1).
- Sub-module rr_arb2:
  - Combinational two-way round-robin picker.
  - Inputs: req[1:0], last. Outputs: gnt_idx, any.
- The FSM, counter and latches stay in mem_arbiter.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 asynchronously, busy=0; after release with no req, state stays IDLE.
- CPU read, RD_LAT=1, mem[0x40]=0x12345678, cpu_req=1 cpu_wr=0 cpu_addr=0x40 → mem_addr=0x40 for 2 cycles, cpu_ack pulses once 3 cycles after req sampling, cpu_rdata=0x12345678, dma_ack=0.
- DMA write addr=0x80 data=0xDEADBEEF → mem_wren=1 exactly one cycle with mem_addr=0x80 and mem_din=0xDEADBEEF; dma_ack next cycle; memory then reads 0xDEADBEEF at 0x80.
- Both req held continuously from reset for 4 transactions → grant order CPU, DMA, CPU, DMA; each ack matches its own address and data.
- RD_LAT=3: CPU read 0x100, rst pulsed during WAIT → no cpu_ack, busy=0; after release a re-issued read of 0x100 completes with cpu_ack 5 cycles after sampling.
- CPU back-to-back reads 0x0 then 0x4 (new addr presented the cycle after ack), DMA idle → exactly one IDLE cycle between ACK and the second ISSUE; both rdata values are correct.
